// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 Hz timing constants and coordinate helpers.
package vga_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_VIS = 640;
  localparam int H_FP  = 16;
  localparam int H_SW  = 96;
  localparam int H_BP  = 48;
  localparam int V_VIS = 480;
  localparam int V_FP  = 10;
  localparam int V_SW  = 2;
  localparam int V_BP  = 33;

  localparam int H_TOTAL      = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOTAL      = V_VIS + V_FP + V_SW + V_BP;
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SW;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SW;

  // Half-open window test used by the sync decoders: lo <= v < hi.
  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_tick_gen.sv
// Pixel-clock divider: o_tick_en is the combinational last-count strobe,
// o_tick is its registered one-clock pulse.
module vga_tick_gen #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick_en,
  output logic o_tick
);

  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);

  if ((DIV < 2) || (DIV > 16)) begin : g_div_range_err
    $error("vga_tick_gen: DIV must be in 2..16");
  end

  logic [3:0] r_div;
  logic       r_tick;
  logic       w_tick_en;

  assign w_tick_en = (r_div == DIV_LAST);
  assign o_tick_en = w_tick_en;
  assign o_tick    = r_tick;

  // Free-running divider and registered tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div  <= 4'd0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_tick_en;
      r_div  <= w_tick_en ? 4'd0 : (r_div + 4'd1);
    end
  end

endmodule

// File: rtl/vga_timing_color_ctrl.sv
// VGA timing generator plus colour-switch synchroniser whose committed
// colour only changes on entry to vertical blanking.
module vga_timing_color_ctrl
  import vga_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int H_VIS = vga_pkg::H_VIS,
  parameter int H_FP  = vga_pkg::H_FP,
  parameter int H_SW  = vga_pkg::H_SW,
  parameter int H_BP  = vga_pkg::H_BP,
  parameter int V_VIS = vga_pkg::V_VIS,
  parameter int V_FP  = vga_pkg::V_FP,
  parameter int V_SW  = vga_pkg::V_SW,
  parameter int V_BP  = vga_pkg::V_BP
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       BotonR,
  input  logic       BotonG,
  input  logic       BotonB,
  output logic       PIX_TICK,
  output logic [9:0] PIX_X,
  output logic [9:0] PIX_Y,
  output logic       H_ON,
  output logic       V_ON,
  output logic       H_SYNC,
  output logic       V_SYNC,
  output logic       FRAME_END,
  output logic       COLOR_R,
  output logic       COLOR_G,
  output logic       COLOR_B
);

  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;

  localparam coord_t X_LAST   = coord_t'(H_TOT - 1);
  localparam coord_t Y_LAST   = coord_t'(V_TOT - 1);
  localparam coord_t Y_COMMIT = coord_t'(V_VIS - 1);
  localparam coord_t H_VIS_C  = coord_t'(H_VIS);
  localparam coord_t V_VIS_C  = coord_t'(V_VIS);
  localparam coord_t HS_START = coord_t'(H_VIS + H_FP);
  localparam coord_t HS_END   = coord_t'(H_VIS + H_FP + H_SW);
  localparam coord_t VS_START = coord_t'(V_VIS + V_FP);
  localparam coord_t VS_END   = coord_t'(V_VIS + V_FP + V_SW);

  if (H_TOT > 1024) begin : g_h_total_err
    $error("vga_timing_color_ctrl: H_TOTAL exceeds 10-bit counter range");
  end
  if (V_TOT > 1024) begin : g_v_total_err
    $error("vga_timing_color_ctrl: V_TOTAL exceeds 10-bit counter range");
  end

  logic       w_tick_en;
  logic       w_commit;
  coord_t     w_x_next;
  coord_t     w_y_next;
  coord_t     r_x;
  coord_t     r_y;
  logic       r_h_on;
  logic       r_v_on;
  logic       r_h_sync;
  logic       r_v_sync;
  logic       r_frame_end;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_color;

  vga_tick_gen #(.DIV(DIV)) u_tick_gen (
    .i_clk     (clk),
    .i_rst_n   (reset_n),
    .o_tick_en (w_tick_en),
    .o_tick    (PIX_TICK)
  );

  // Next-state raster position; advances only on the divider's last count.
  always_comb begin
    w_x_next = r_x;
    w_y_next = r_y;
    if (w_tick_en) begin
      if (r_x == X_LAST) begin
        w_x_next = 10'd0;
        if (r_y == Y_LAST) begin
          w_y_next = 10'd0;
        end else begin
          w_y_next = r_y + 10'd1;
        end
      end else begin
        w_x_next = r_x + 10'd1;
      end
    end else begin
      w_x_next = r_x;
      w_y_next = r_y;
    end
  end

  // Commit lands on the edge that moves the raster onto the first blanking line.
  assign w_commit = w_tick_en && (r_x == X_LAST) && (r_y == Y_COMMIT);

  // Counters, decode from next-state (zero skew), synchroniser and colour hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x         <= 10'd0;
      r_y         <= 10'd0;
      r_h_on      <= 1'b1;
      r_v_on      <= 1'b1;
      r_h_sync    <= 1'b1;
      r_v_sync    <= 1'b1;
      r_frame_end <= 1'b0;
      r_sync1     <= 3'b000;
      r_sync2     <= 3'b000;
      r_color     <= 3'b000;
    end else begin
      r_x         <= w_x_next;
      r_y         <= w_y_next;
      r_h_on      <= (w_x_next < H_VIS_C);
      r_v_on      <= (w_y_next < V_VIS_C);
      r_h_sync    <= !in_range(w_x_next, HS_START, HS_END);
      r_v_sync    <= !in_range(w_y_next, VS_START, VS_END);
      r_frame_end <= w_commit;
      r_sync1     <= {BotonR, BotonG, BotonB};
      r_sync2     <= r_sync1;
      r_color     <= w_commit ? r_sync2 : r_color;
    end
  end

  assign PIX_X     = r_x;
  assign PIX_Y     = r_y;
  assign H_ON      = r_h_on;
  assign V_ON      = r_v_on;
  assign H_SYNC    = r_h_sync;
  assign V_SYNC    = r_v_sync;
  assign FRAME_END = r_frame_end;
  assign COLOR_R   = r_color[2];
  assign COLOR_G   = r_color[1];
  assign COLOR_B   = r_color[0];

endmodule

// File: tb/tb_vga_timing_color_ctrl.sv
// Directed bench for vga_timing_color_ctrl on a shrunken raster (25x17, DIV=4)
// so whole frames fit in a short run.
module tb_vga_timing_color_ctrl;

  localparam int DIV   = 4;
  localparam int H_VIS = 16;
  localparam int H_FP  = 2;
  localparam int H_SW  = 4;
  localparam int H_BP  = 3;
  localparam int V_VIS = 10;
  localparam int V_FP  = 2;
  localparam int V_SW  = 2;
  localparam int V_BP  = 3;

  logic       clk;
  logic       reset_n;
  logic       BotonR, BotonG, BotonB;
  logic       PIX_TICK;
  logic [9:0] PIX_X, PIX_Y;
  logic       H_ON, V_ON, H_SYNC, V_SYNC, FRAME_END;
  logic       COLOR_R, COLOR_G, COLOR_B;

  int n_vec = 0;
  int n_err = 0;

  vga_timing_color_ctrl #(
    .DIV(DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .BotonR(BotonR), .BotonG(BotonG), .BotonB(BotonB),
    .PIX_TICK(PIX_TICK), .PIX_X(PIX_X), .PIX_Y(PIX_Y),
    .H_ON(H_ON), .V_ON(V_ON), .H_SYNC(H_SYNC), .V_SYNC(V_SYNC),
    .FRAME_END(FRAME_END),
    .COLOR_R(COLOR_R), .COLOR_G(COLOR_G), .COLOR_B(COLOR_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] color();
    return {COLOR_R, COLOR_G, COLOR_B};
  endfunction

  // Packed view of the reset-time outputs: tick,x,y,hon,von,hs,vs,fe,rgb.
  function automatic logic [31:0] rst_view();
    return {3'd0, PIX_TICK, PIX_X, PIX_Y, H_ON, V_ON, H_SYNC, V_SYNC, FRAME_END, COLOR_R, COLOR_G, COLOR_B};
  endfunction

  localparam logic [31:0] RST_EXP = {3'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000};

  task automatic run_to(input string tag, input int y, input int x);
    int n;
    n = 0;
    while (!(PIX_TICK && (PIX_Y == 10'(y)) && (PIX_X == 10'(x))) && (n < 4000)) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (n < 4000), 1'b1);
  endtask

  // Waits for FRAME_END; reports clocks where colour moved before it.
  task automatic wait_fe(input string tag, input logic [2:0] held);
    int n;
    int moved;
    n = 0;
    moved = 0;
    @(negedge clk);
    while (!FRAME_END && (n < 4000)) begin
      if (color() != held) moved++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_fe_seen"}, (n < 4000), 1'b1);
    chk({tag, "_held"}, moved, 0);
  endtask

  initial begin
    int n_hs_low, n_hon_low, first_hs_x, prev_x, n_clk, n;
    int n_vs_low, vs_min, vs_max, n_von_low, n_fe, fe_x, fe_y, prev_y;
    reset_n = 1'b0;
    BotonR = 1'b0; BotonG = 1'b0; BotonB = 1'b0;

    // Reset hold: outputs at reset values even with switches moving.
    repeat (2) @(negedge clk);
    chk("reset_hold", rst_view(), RST_EXP);
    BotonR = 1'b1; BotonG = 1'b1; BotonB = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_hold_sw", rst_view(), RST_EXP);
    BotonR = 1'b0; BotonG = 1'b0; BotonB = 1'b0;

    // Release: tick on clk 4,8,...; PIX_X = 4 after 16 clks.
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("tick_clk%0d", k), PIX_TICK, (k % 4) == 0);
      if (k == 16) chk("x_after16", PIX_X, 10'd4);
    end
    chk("x_after20", PIX_X, 10'd5);

    // One full line from x=5 on line 0 until the wrap to (0,1).
    n_hs_low = 0; n_hon_low = 0; first_hs_x = -1; prev_x = -1; n = 0;
    do begin
      if (PIX_TICK) prev_x = int'(PIX_X);
      @(negedge clk);
      n++;
      if (PIX_TICK && !H_SYNC) begin
        n_hs_low++;
        if (first_hs_x < 0) first_hs_x = int'(PIX_X);
      end
      if (PIX_TICK && !H_ON) n_hon_low++;
    end while (!(PIX_TICK && PIX_X == 10'd0 && PIX_Y == 10'd1) && n < 200);
    chk("line_wrap_seen", (n < 200), 1'b1);
    chk("hs_low_ticks", n_hs_low, 4);
    chk("hs_first_x", first_hs_x, 18);
    chk("hon_low_ticks", n_hon_low, 9);
    chk("x_before_wrap", prev_x, 24);
    chk("wrap_hon_hs", {H_ON, H_SYNC}, 2'b11);

    // One full frame from (0,1) back to (0,1).
    n_clk = 0; n_vs_low = 0; vs_min = 999; vs_max = -1; n_von_low = 0;
    n_fe = 0; fe_x = -1; fe_y = -1; prev_y = -1;
    do begin
      if (PIX_TICK && PIX_X == 10'd24) prev_y = int'(PIX_Y);
      @(negedge clk);
      n_clk++;
      if (PIX_TICK && !V_SYNC) begin
        n_vs_low++;
        if (int'(PIX_Y) < vs_min) vs_min = int'(PIX_Y);
        if (int'(PIX_Y) > vs_max) vs_max = int'(PIX_Y);
      end
      if (PIX_TICK && !V_ON) n_von_low++;
      if (FRAME_END) begin
        n_fe++;
        fe_x = int'(PIX_X);
        fe_y = int'(PIX_Y);
      end
      if (PIX_TICK && PIX_X == 10'd0 && PIX_Y == 10'd0) chk("y_before_wrap", prev_y, 16);
    end while (!(PIX_TICK && PIX_X == 10'd0 && PIX_Y == 10'd1) && n_clk < 3000);
    chk("frame_clks", n_clk, 1700);
    chk("vs_low_ticks", n_vs_low, 50);
    chk("vs_first_line", vs_min, 12);
    chk("vs_last_line", vs_max, 13);
    chk("von_low_ticks", n_von_low, 175);
    chk("fe_count", n_fe, 1);
    chk("fe_pos", {fe_y[15:0], fe_x[15:0]}, {16'd10, 16'd0});

    // Colour commit: R,B set mid-frame, visible only after FRAME_END.
    run_to("reach_y3", 3, 0);
    BotonR = 1'b1; BotonB = 1'b1;
    wait_fe("rb", 3'b000);
    chk("color_101", color(), 3'b101);
    run_to("reach_y5", 5, 0);
    BotonG = 1'b1;
    run_to("reach_y8", 8, 0);
    chk("g_not_yet", color(), 3'b101);
    wait_fe("g", 3'b101);
    chk("color_111", color(), 3'b111);

    // G drops one clk before commit edge: missed, then taken next frame.
    run_to("reach_pre1", 9, 24);
    repeat (3) @(negedge clk);
    BotonG = 1'b0;
    @(negedge clk);
    chk("fe_at_pre1", FRAME_END, 1'b1);
    chk("g_late_missed", color(), 3'b111);
    wait_fe("g_late", 3'b111);
    chk("g_late_next", color(), 3'b101);

    // G rises three clks before commit edge: captured.
    run_to("reach_pre3", 9, 24);
    @(negedge clk);
    BotonG = 1'b1;
    repeat (3) @(negedge clk);
    chk("fe_at_pre3", FRAME_END, 1'b1);
    chk("g_early_taken", color(), 3'b111);

    // Mid-frame asynchronous reset with colour 111.
    run_to("reach_mid", 6, 12);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", rst_view(), RST_EXP);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (16) @(negedge clk);
    chk("restart_xy", {PIX_Y, PIX_X}, {10'd0, 10'd4});
    chk("restart_color", color(), 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
